// File: rtl/lsu_pkg.sv
// Shared encodings for the load/store path: decoder size/extension codes and
// the access FSM states.
package lsu_pkg;

   localparam logic [1:0] BA_WORD = 2'b00;
   localparam logic [1:0] BA_BYTE = 2'b01;
   localparam logic [1:0] BA_HALF = 2'b10;

   localparam logic [2:0] BS_LBU = 3'b000;
   localparam logic [2:0] BS_LHU = 3'b001;
   localparam logic [2:0] BS_LB  = 3'b010;
   localparam logic [2:0] BS_LH  = 3'b011;
   localparam logic [2:0] BS_LW  = 3'b100;

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_CMD0 = 3'd1,
      ST_RD0  = 3'd2,
      ST_CMD1 = 3'd3,
      ST_RD1  = 3'd4,
      ST_DONE = 3'd5
   } state_t;

   // Byte-lane mask of an access at offset 0; ByteAccess 11 falls into word.
   function automatic logic [3:0] size_mask(input logic [1:0] ba);
      case (ba)
         BA_BYTE: size_mask = 4'b0001;
         BA_HALF: size_mask = 4'b0011;
         default: size_mask = 4'b1111;
      endcase
   endfunction

   // True when the access spills into the next word.
   function automatic logic crosses(input logic [1:0] ba, input logic [1:0] off);
      case (ba)
         BA_BYTE: crosses = 1'b0;
         BA_HALF: crosses = (off == 2'd3);
         default: crosses = (off != 2'd0);
      endcase
   endfunction

endpackage

// File: rtl/load_extend.sv
// Aligns up to two collected read beats to the access offset and applies
// zero/sign extension selected by ByteSrc.
module load_extend
   import lsu_pkg::*;
(
   input  logic [63:0] rdata,
   input  logic [1:0]  off,
   input  logic [2:0]  byte_src,
   output logic [31:0] result
);

   logic [31:0] raw;

   assign raw = 32'(rdata >> {off, 3'b000});

   always_comb begin
      result = raw;
      case (byte_src)
         BS_LBU:  result = {24'b0, raw[7:0]};
         BS_LHU:  result = {16'b0, raw[15:0]};
         BS_LB:   result = {{24{raw[7]}}, raw[7:0]};
         BS_LH:   result = {{16{raw[15]}}, raw[15:0]};
         default: result = raw;
      endcase
   end

endmodule

// File: rtl/mem_access_unit.sv
// Data-memory access unit: turns one core load/store into one or two
// word-aligned bus beats and returns the aligned, extended load result.
module mem_access_unit
   import lsu_pkg::*;
#(
   parameter int ADDR_W   = 32,
   parameter int SPLIT_EN = 1
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_we,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [31:0]       req_wdata,
   input  logic [1:0]        ByteAccess,
   input  logic [2:0]        ByteSrc,
   output logic              rsp_valid,
   output logic [31:0]       rsp_rdata,
   output logic              rsp_err,
   output logic              bus_valid,
   input  logic              bus_ready,
   output logic              bus_we,
   output logic [ADDR_W-1:0] bus_addr,
   output logic [3:0]        bus_wstrb,
   output logic [31:0]       bus_wdata,
   input  logic              bus_rvalid,
   input  logic [31:0]       bus_rdata
);

   localparam bit REJECT = (SPLIT_EN == 0);

   state_t            state_q, state_d;
   logic              we_q;
   logic [ADDR_W-1:0] addr_q;
   logic [31:0]       wdata_q;
   logic [3:0]        smask_q;
   logic [2:0]        ext_q;
   logic [31:0]       rd0_q;
   logic [31:0]       rsp_rdata_q;
   logic              err_q;

   logic              accept, reject, split, beat1;
   logic [1:0]        off;
   logic [7:0]        mask8;
   logic [63:0]       data64;
   logic [ADDR_W-1:0] base_addr;
   logic [31:0]       ext_rd0, ext_rd1, ext_result;
   logic              rd_take, rd_last;

   assign accept = req_valid && req_ready;
   assign reject = REJECT && crosses(ByteAccess, req_addr[1:0]);

   assign off       = addr_q[1:0];
   assign mask8     = {4'b0, smask_q} << off;
   assign data64    = {32'b0, wdata_q} << {off, 3'b000};
   assign split     = (mask8[7:4] != 4'b0);
   assign base_addr = {addr_q[ADDR_W-1:2], 2'b00};
   assign beat1     = (state_q == ST_CMD1);

   assign req_ready = (state_q == ST_IDLE);
   assign rsp_valid = (state_q == ST_DONE);
   assign rsp_err   = rsp_valid && err_q;
   assign rsp_rdata = rsp_rdata_q;

   assign bus_valid = (state_q == ST_CMD0) || beat1;
   assign bus_we    = bus_valid && we_q;
   assign bus_addr  = beat1 ? base_addr + ADDR_W'(4) : base_addr;
   assign bus_wstrb = !bus_valid ? 4'b0 : (beat1 ? mask8[7:4] : mask8[3:0]);
   assign bus_wdata = beat1 ? data64[63:32] : data64[31:0];

   // Read data is consumed straight off the bus on the beat that finishes
   // the load, so the result is ready the cycle DONE is entered.
   assign rd_take = bus_rvalid && ((state_q == ST_RD0) || (state_q == ST_RD1));
   assign rd_last = rd_take && ((state_q == ST_RD1) || !split);
   assign ext_rd1 = (state_q == ST_RD1) ? bus_rdata : 32'b0;
   assign ext_rd0 = (state_q == ST_RD0) ? bus_rdata : rd0_q;

   load_extend u_ext (
      .rdata    ({ext_rd1, ext_rd0}),
      .off      (off),
      .byte_src (ext_q),
      .result   (ext_result)
   );

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: if (accept) state_d = reject ? ST_DONE : ST_CMD0;
         ST_CMD0: if (bus_ready) state_d = !we_q ? ST_RD0 : (split ? ST_CMD1 : ST_DONE);
         ST_RD0:  if (bus_rvalid) state_d = split ? ST_CMD1 : ST_DONE;
         ST_CMD1: if (bus_ready) state_d = we_q ? ST_DONE : ST_RD1;
         ST_RD1:  if (bus_rvalid) state_d = ST_DONE;
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= ST_IDLE;
         we_q        <= 1'b0;
         addr_q      <= '0;
         wdata_q     <= '0;
         smask_q     <= 4'b0;
         ext_q       <= 3'b0;
         rd0_q       <= '0;
         rsp_rdata_q <= '0;
         err_q       <= 1'b0;
      end else begin
         state_q <= state_d;
         if (accept) begin
            we_q    <= req_we;
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
            smask_q <= size_mask(ByteAccess);
            ext_q   <= ByteSrc;
            err_q   <= reject;
         end
         if (bus_rvalid && (state_q == ST_RD0)) rd0_q <= bus_rdata;
         if (rd_last) rsp_rdata_q <= ext_result;
      end
   end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench: split-capable unit plus a reject-mode unit, cycle-exact checks.
module tb_mem_access_unit;
   import lsu_pkg::*;

   logic        clk = 1'b0;
   logic        reset_n;

   logic        req_valid, req_we, bus_ready, bus_rvalid;
   logic [31:0] req_addr, req_wdata, bus_rdata;
   logic [1:0]  ba;
   logic [2:0]  bs;
   logic        req_ready, rsp_valid, rsp_err, bus_valid, bus_we;
   logic [31:0] rsp_rdata, bus_addr, bus_wdata;
   logic [3:0]  bus_wstrb;

   logic        r_req_valid, r_req_we, r_bus_ready, r_bus_rvalid;
   logic [31:0] r_req_addr, r_req_wdata, r_bus_rdata;
   logic [1:0]  r_ba;
   logic [2:0]  r_bs;
   logic        r_req_ready, r_rsp_valid, r_rsp_err, r_bus_valid, r_bus_we;
   logic [31:0] r_rsp_rdata, r_bus_addr, r_bus_wdata;
   logic [3:0]  r_bus_wstrb;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   mem_access_unit #(.ADDR_W(32), .SPLIT_EN(1)) u_dut (
      .clk(clk), .reset_n(reset_n),
      .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
      .req_addr(req_addr), .req_wdata(req_wdata), .ByteAccess(ba), .ByteSrc(bs),
      .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
      .bus_valid(bus_valid), .bus_ready(bus_ready), .bus_we(bus_we),
      .bus_addr(bus_addr), .bus_wstrb(bus_wstrb), .bus_wdata(bus_wdata),
      .bus_rvalid(bus_rvalid), .bus_rdata(bus_rdata)
   );

   mem_access_unit #(.ADDR_W(32), .SPLIT_EN(0)) u_rej (
      .clk(clk), .reset_n(reset_n),
      .req_valid(r_req_valid), .req_ready(r_req_ready), .req_we(r_req_we),
      .req_addr(r_req_addr), .req_wdata(r_req_wdata), .ByteAccess(r_ba), .ByteSrc(r_bs),
      .rsp_valid(r_rsp_valid), .rsp_rdata(r_rsp_rdata), .rsp_err(r_rsp_err),
      .bus_valid(r_bus_valid), .bus_ready(r_bus_ready), .bus_we(r_bus_we),
      .bus_addr(r_bus_addr), .bus_wstrb(r_bus_wstrb), .bus_wdata(r_bus_wdata),
      .bus_rvalid(r_bus_rvalid), .bus_rdata(r_bus_rdata)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      reset_n = 1'b0;
      req_valid = 0; req_we = 0; req_addr = 0; req_wdata = 0; ba = 0; bs = 0;
      bus_ready = 1; bus_rvalid = 0; bus_rdata = 0;
      r_req_valid = 0; r_req_we = 0; r_req_addr = 0; r_req_wdata = 0; r_ba = 0; r_bs = 0;
      r_bus_ready = 1; r_bus_rvalid = 0; r_bus_rdata = 0;
      tick(); tick();
      chk("rst_req_ready", 32'(req_ready), 32'd1);
      chk("rst_bus_valid", 32'(bus_valid), 32'd0);
      chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
      chk("rst_rsp_err",   32'(rsp_err),   32'd0);
      chk("rst_rsp_rdata", rsp_rdata,      32'h0);
      chk("rst_bus_we",    32'(bus_we),    32'd0);
      chk("rst_bus_wstrb", 32'(bus_wstrb), 32'd0);
      reset_n = 1'b1;

      // store byte 0x1003
      req_valid = 1; req_we = 1; req_addr = 32'h1003; req_wdata = 32'h000000AB;
      ba = BA_BYTE; bs = BS_LW;
      tick();
      req_valid = 0;
      chk("sb_c1_valid", 32'(bus_valid), 32'd1);
      chk("sb_c1_we",    32'(bus_we),    32'd1);
      chk("sb_c1_addr",  bus_addr,       32'h1000);
      chk("sb_c1_strb",  32'(bus_wstrb), 32'h8);
      chk("sb_c1_wdata", bus_wdata,      32'hAB000000);
      chk("sb_c1_ready", 32'(req_ready), 32'd0);
      chk("sb_c1_rsp",   32'(rsp_valid), 32'd0);
      tick();
      chk("sb_c2_rsp",   32'(rsp_valid), 32'd1);
      chk("sb_c2_err",   32'(rsp_err),   32'd0);
      chk("sb_c2_bus",   32'(bus_valid), 32'd0);
      tick();
      chk("sb_c3_rsp",   32'(rsp_valid), 32'd0);
      chk("sb_c3_ready", 32'(req_ready), 32'd1);

      // load half signed 0x2002
      req_valid = 1; req_we = 0; req_addr = 32'h2002; ba = BA_HALF; bs = BS_LH;
      tick();
      req_valid = 0;
      chk("lh_c1_valid", 32'(bus_valid), 32'd1);
      chk("lh_c1_we",    32'(bus_we),    32'd0);
      chk("lh_c1_addr",  bus_addr,       32'h2000);
      tick();
      chk("lh_c2_bus",   32'(bus_valid), 32'd0);
      chk("lh_c2_rsp",   32'(rsp_valid), 32'd0);
      bus_rvalid = 1; bus_rdata = 32'h80FF1234;
      tick();
      bus_rvalid = 0;
      chk("lh_c3_rsp",   32'(rsp_valid), 32'd1);
      chk("lh_c3_rdata", rsp_rdata,      32'hFFFF80FF);
      tick();

      // split load word 0x3001
      req_valid = 1; req_we = 0; req_addr = 32'h3001; ba = BA_WORD; bs = BS_LW;
      tick();
      req_valid = 0;
      chk("lw_c1_addr",  bus_addr,       32'h3000);
      tick();
      bus_rvalid = 1; bus_rdata = 32'h44332211;
      tick();
      bus_rvalid = 0;
      chk("lw_c3_valid", 32'(bus_valid), 32'd1);
      chk("lw_c3_addr",  bus_addr,       32'h3004);
      chk("lw_c3_rsp",   32'(rsp_valid), 32'd0);
      tick();
      chk("lw_c4_rsp",   32'(rsp_valid), 32'd0);
      bus_rvalid = 1; bus_rdata = 32'h88776655;
      tick();
      bus_rvalid = 0;
      chk("lw_c5_rsp",   32'(rsp_valid), 32'd1);
      chk("lw_c5_rdata", rsp_rdata,      32'h55443322);
      tick();

      // split store word 0x0FFF, beat 0 stalled three cycles
      req_valid = 1; req_we = 1; req_addr = 32'h0FFF; req_wdata = 32'hDDCCBBAA;
      ba = BA_WORD; bus_ready = 0;
      tick();
      req_valid = 0;
      for (int c = 0; c < 3; c++) begin
         chk("sw_stall_valid", 32'(bus_valid), 32'd1);
         chk("sw_stall_addr",  bus_addr,       32'h0FFC);
         chk("sw_stall_strb",  32'(bus_wstrb), 32'h8);
         chk("sw_stall_wdata", bus_wdata,      32'hAA000000);
         if (c == 2) bus_ready = 1;
         tick();
      end
      chk("sw_b1_valid", 32'(bus_valid), 32'd1);
      chk("sw_b1_addr",  bus_addr,       32'h1000);
      chk("sw_b1_strb",  32'(bus_wstrb), 32'h7);
      chk("sw_b1_wdata", bus_wdata,      32'h00DDCCBB);
      tick();
      chk("sw_rsp",      32'(rsp_valid), 32'd1);
      chk("sw_rdata_kept", rsp_rdata,    32'h55443322);
      tick();

      // reject-mode unit: misaligned half load
      r_req_valid = 1; r_req_we = 0; r_req_addr = 32'h0007; r_ba = BA_HALF; r_bs = BS_LH;
      tick();
      r_req_valid = 0;
      chk("rej_bus",   32'(r_bus_valid), 32'd0);
      chk("rej_rsp",   32'(r_rsp_valid), 32'd1);
      chk("rej_err",   32'(r_rsp_err),   32'd1);
      tick();
      chk("rej_c2_rsp",   32'(r_rsp_valid), 32'd0);
      chk("rej_c2_ready", 32'(r_req_ready), 32'd1);
      chk("rej_c2_bus",   32'(r_bus_valid), 32'd0);

      // reset while waiting in RD0
      req_valid = 1; req_we = 0; req_addr = 32'h2000; ba = BA_WORD; bs = BS_LW;
      tick();
      req_valid = 0;
      tick();
      reset_n = 1'b0;
      #1;
      chk("mr_ready", 32'(req_ready), 32'd1);
      chk("mr_bus",   32'(bus_valid), 32'd0);
      chk("mr_rsp",   32'(rsp_valid), 32'd0);
      chk("mr_rdata", rsp_rdata,      32'h0);
      tick();
      reset_n = 1'b1;
      bus_rvalid = 1; bus_rdata = 32'hCAFEF00D;
      tick();
      bus_rvalid = 0;
      chk("mr_post_rsp",   32'(rsp_valid), 32'd0);
      chk("mr_post_ready", 32'(req_ready), 32'd1);
      tick();
      chk("mr_post2_rsp",  32'(rsp_valid), 32'd0);
      chk("mr_post_rdata", rsp_rdata,      32'h0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
